// File: rtl/nar_pkg.sv
// rtl/nar_pkg.sv - shared FSM state type and default weight-store dimensions.
package nar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int WEIGHT_W     = 8;
  localparam int WEIGHT_DEPTH = 256;

endpackage

// File: rtl/weights_skid_buf.sv
// rtl/weights_skid_buf.sv - 2-entry valid/ready buffer with bypass when empty.
module weights_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              almost_full,
  output logic              empty_next
);

  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic              push;
  logic              pop;

  // Input cannot be refused; the producer must watch almost_full before issuing.
  always_comb begin
    pop         = (count != 2'd0) && out_ready;
    push        = in_valid && !((count == 2'd0) && out_ready);
    count_next  = count + {1'b0, push} - {1'b0, pop};
    almost_full = count_next[1];
    empty_next  = (count_next == 2'd0);
    out_valid   = (count != 2'd0) || in_valid;
    out_data    = (count != 2'd0) ? e0 : in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      count <= count_next;
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        2'b01: e0 <= e1;
        2'b10: begin
          if (count == 2'd0) e0 <= in_data;
          else               e1 <= in_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weights_stream_rom.sv
// rtl/weights_stream_rom.sv - loadable weight RAM with burst read sequencer and valid/ready stream.
module weights_stream_rom
  import nar_pkg::*;
#(
  parameter int    DATA_W   = WEIGHT_W,
  parameter int    DEPTH    = WEIGHT_DEPTH,
  parameter int    ADDR_W   = 8,
  parameter int    LEN_W    = 9,
  parameter string INIT_HEX = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [LEN_W-1:0]         burst_len,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic signed [DATA_W-1:0] w_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  rem_next;
  logic              done_next;
  logic              issue;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] skid_data;
  logic              almost_full;
  logic              empty_next;
  logic              wr_ok;
  logic              rd_in_range;
  logic              ptr_wrap;

  assign wr_ok       = wr_en && ({1'b0, wr_addr} < DEPTH_V);
  assign rd_in_range = {1'b0, ptr} < DEPTH_V;
  assign ptr_wrap    = ({1'b0, ptr} == DEPTH_V - 1'b1);

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Separate non-blocking read gives read-first behaviour on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= issue;
      if (issue) rd_data <= rd_in_range ? mem[ptr] : '0;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    rem_next   = rem;
    done_next  = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            done_next = 1'b1;
          end else begin
            ptr_next   = start_addr;
            rem_next   = burst_len;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!almost_full) begin
          issue    = 1'b1;
          ptr_next = ptr_wrap ? '0 : ptr + 1'b1;
          rem_next = rem - 1'b1;
          if (rem == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // empty_next already accounts for a transfer on this edge.
        if (empty_next) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      rem   <= rem_next;
      done  <= done_next;
    end
  end

  assign busy   = (state != IDLE);
  assign w_data = skid_data;

  weights_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_valid),
    .in_data    (rd_data),
    .out_valid  (w_valid),
    .out_ready  (w_ready),
    .out_data   (skid_data),
    .almost_full(almost_full),
    .empty_next (empty_next)
  );

endmodule

// File: tb/tb_weights_stream_rom.sv
// tb/tb_weights_stream_rom.sv - randomized bench for weights_stream_rom against a queue-based burst model.
module tb_weights_stream_rom;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic [7:0]        start_addr;
  logic [8:0]        burst_len;
  logic              w_valid;
  logic              w_ready;
  logic signed [7:0] w_data;
  logic              busy;
  logic              done;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_mem [256];

  always #5 clk = ~clk;

  weights_stream_rom dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .start_addr(start_addr),
    .burst_len (burst_len),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic load(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[7:0];
    wr_data = d[7:0];
    model_mem[a] = d[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // mode: 0 = ready held high, 1 = ready pattern 1,0,0,1, 2 = random ready plus stray start pulses.
  task automatic run_burst(input int sa, input int len, input int mode, input int abort_at,
                           input int wr_cyc, input int wr_a, input int wr_d);
    logic [7:0] exp_q[$];
    int         n_x;
    int         a;
    int         prev_d;
    bit         prev_stall;
    bit         got_all;
    a = sa;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_mem[a]);
      a = (a + 1) % 256;
    end
    n_x        = 0;
    prev_d     = 0;
    prev_stall = 1'b0;
    got_all    = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa[7:0];
    burst_len  = len[8:0];
    w_ready    = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc == wr_cyc) begin
        wr_en   = 1'b1;
        wr_addr = wr_a[7:0];
        wr_data = wr_d[7:0];
        model_mem[wr_a] = wr_d[7:0];
      end
      if (got_all) begin
        check("done_pulse", int'(done), 1);
        check("busy_fall", int'(busy), 0);
        check("valid_after_burst", int'(w_valid), 0);
        if (mode == 0) check("done_cycle", cyc, len + 2);
        @(negedge clk);
        wr_en = 1'b0;
        check("done_single", int'(done), 0);
        return;
      end
      if (abort_at > 0 && n_x == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", int'(w_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_data", int'(w_data), 0);
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        return;
      end
      check("done_low", int'(done), 0);
      check("busy_high", int'(busy), 1);
      if (cyc == 1) check("first_latency", int'(w_valid), 0);
      if (cyc == 2 && mode == 0) check("first_valid", int'(w_valid), 1);
      if (prev_stall) begin
        check("stall_valid", int'(w_valid), 1);
        check("stall_data", int'(w_data), prev_d);
      end
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: begin
          w_ready    = 1'($urandom_range(0, 1));
          start      = 1'($urandom_range(0, 1));
          start_addr = 8'($urandom_range(0, 255));
          burst_len  = 9'($urandom_range(1, 20));
        end
      endcase
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat", int'(w_data), int'($signed(exp_q.pop_front())));
          n_x++;
          if (n_x == len) got_all = 1'b1;
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_d     = int'(w_data);
    end
    check("burst_timeout", n_x, -1);
  endtask

  initial begin
    int sa;
    int len;
    int newv;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    w_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(w_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_data", int'(w_data), 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) load(i, int'($urandom_range(0, 255)));

    load(0, 'h3E); load(1, 'h36); load(2, 'hF6); load(3, 'h41);
    run_burst(0, 4, 0, 0, 0, 0, 0);
    run_burst(0, 4, 1, 0, 0, 0, 0);

    load(254, 1); load(255, 2); load(0, 3); load(1, 4);
    run_burst(254, 4, 0, 0, 0, 0, 0);

    @(negedge clk);
    start      = 1'b1;
    start_addr = 8'd5;
    burst_len  = 9'd0;
    w_ready    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", int'(done), 1);
    check("len0_busy", int'(busy), 0);
    check("len0_valid", int'(w_valid), 0);
    @(negedge clk);
    check("len0_done_once", int'(done), 0);
    check("len0_busy_after", int'(busy), 0);
    check("len0_valid_after", int'(w_valid), 0);

    newv = int'(model_mem[12] ^ 8'hFF);
    run_burst(10, 4, 0, 0, 3, 12, newv);
    run_burst(12, 1, 0, 0, 0, 0, 0);

    run_burst(0, 8, 0, 2, 0, 0, 0);
    run_burst(0, 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      sa  = int'($urandom_range(0, 255));
      len = int'($urandom_range(1, 12));
      if (k % 3 == 0) load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run_burst(sa, len, (k % 2 == 0) ? 2 : 1, 0, 0, 0, 0);
    end
    run_burst(100, 256, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
